snake_input_ctrl: RTL and testbench

Input conditioning stage directly upstream of the Snake Game core. Synchronises and debounces the four raw active-low direction push buttons and the raw pause input. Turns presses into a registered heading that changes only on the core's game-step tick and never reverses onto itself, and maintains the pause state. Its outputs drive the core's direction, pause and clean push inputs.

---
 rtl/snake_input_ctrl_if.sv | 54 +++++
 rtl/snake_input_ctrl.sv | 172 +++++++++++++++++
 tb/tb_snake_input_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/snake_input_ctrl_if.sv
// ----------------------------------------------------------------------------
// snake_input_ctrl_if
//
// Purpose:
//   Bundles the signals between the raw button inputs, the game core and the
//   snake_input_ctrl conditioning stage. Clock and reset are not part of the
//   bundle; they stay plain ports on the module.
//
// Signals:
//   i_Push   [3:0]  raw direction buttons, active-low (bit0 up, bit1 down,
//                   bit2 left, bit3 right), idle 4'b1111
//   i_Pause         raw pause button, active-high
//   i_Tick          one-cycle game-step pulse from the core
//   o_Push   [3:0]  debounced direction buttons, active-low
//   o_Dir    [1:0]  committed heading (0 up, 1 down, 2 left, 3 right)
//   o_DirChg        one-cycle pulse when o_Dir changes value
//   o_Pause         pause state, level
//
// Modports:
//   master  - the side that drives the raw inputs and tick and consumes the
//             conditioned outputs (board inputs plus game core)
//   slave   - the conditioning stage itself
// ----------------------------------------------------------------------------
interface snake_input_ctrl_if;

    logic [3:0] i_Push;
    logic       i_Pause;
    logic       i_Tick;
    logic [3:0] o_Push;
    logic [1:0] o_Dir;
    logic       o_DirChg;
    logic       o_Pause;

    modport master (
        output i_Push,
        output i_Pause,
        output i_Tick,
        input  o_Push,
        input  o_Dir,
        input  o_DirChg,
        input  o_Pause
    );

    modport slave (
        input  i_Push,
        input  i_Pause,
        input  i_Tick,
        output o_Push,
        output o_Dir,
        output o_DirChg,
        output o_Pause
    );

endinterface

// File: rtl/snake_input_ctrl.sv
// ----------------------------------------------------------------------------
// snake_input_ctrl
//
// Purpose:
//   Input conditioning stage in front of the Snake Game core. The four raw
//   direction buttons and the raw pause button are synchronised and
//   debounced. Button presses become a pending heading that is committed
//   to o_Dir only on the core's game-step tick, and a heading that would
//   turn the snake straight back onto itself is refused. A pause press
//   toggles the pause state, during which presses and ticks are ignored.
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a synchronised input must hold a new level
//                    before it is accepted (minimum 2)
//   CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports:
//   Clk   system clock, rising edge
//   Rst   synchronous active-high reset
//   bus   snake_input_ctrl_if.slave (raw inputs, tick, conditioned outputs)
// ----------------------------------------------------------------------------
module snake_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic              Clk,
    input  logic              Rst,
    snake_input_ctrl_if.slave bus
);

    // Bits 0..3 are the direction buttons, bit 4 is the pause button.
    localparam int               NBITS     = 5;
    localparam int               PAUSE_BIT = 4;
    // Idle level of each input: buttons released high, pause released low.
    localparam logic [NBITS-1:0] IDLE_LVL  = 5'b01111;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [1:0]       DIR_RIGHT = 2'd3;

    logic [NBITS-1:0] raw;

    logic [NBITS-1:0] sync1_q, sync1_d;
    logic [NBITS-1:0] sync2_q, sync2_d;
    logic [NBITS-1:0] stable_q, stable_d;
    logic [NBITS-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q [NBITS];
    logic [CNT_W-1:0] cnt_d [NBITS];

    logic [1:0]       pending_q, pending_d;
    logic [1:0]       dir_q, dir_d;
    logic             dir_chg_q, dir_chg_d;
    logic             pause_q, pause_d;

    logic [3:0]       press_evt;
    logic             pause_evt;
    logic             cand_valid;
    logic [1:0]       cand_dir;
    logic [1:0]       opposite_dir;

    assign raw = {bus.i_Pause, bus.i_Push};

    // Two-flop synchroniser chain, one chain per input bit.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
    end

    // Per-bit debounce. The counter only runs while the synchronised level
    // disagrees with the accepted level; any return to agreement clears it,
    // so a glitch shorter than DEBOUNCE_CYCLES leaves no trace.
    always_comb begin
        stable_d = stable_q;
        for (int k = 0; k < NBITS; k++) begin
            cnt_d[k] = '0;
            if (sync2_q[k] != stable_q[k]) begin
                if (cnt_q[k] == CNT_MAX) begin
                    stable_d[k] = sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_ONE;
                end
            end
        end
    end

    // Edge detection on the accepted levels. A direction press is the
    // active-low button going 1 -> 0; a pause press is 0 -> 1. Releases
    // produce nothing.
    always_comb begin
        prev_d    = stable_q;
        press_evt = prev_q[3:0] & ~stable_q[3:0];
        pause_evt = ~prev_q[PAUSE_BIT] & stable_q[PAUSE_BIT];
    end

    // Pick a single candidate heading. Scanning from the top index down
    // leaves the lowest-index press as the winner when several coincide.
    always_comb begin
        cand_valid = |press_evt;
        cand_dir   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (press_evt[k]) begin
                cand_dir = 2'(k);
            end
        end
    end

    // Pending heading. The reversal check is made against the committed
    // heading rather than the pending one, so no run of presses between two
    // ticks can walk the pending value round to a 180 degree turn.
    // Presses are judged against the pause state before any toggle in the
    // same cycle.
    always_comb begin
        opposite_dir = dir_q ^ 2'b01;
        pending_d    = pending_q;
        if (cand_valid && !pause_q && (cand_dir != opposite_dir)) begin
            pending_d = cand_dir;
        end
    end

    // Commit on the game tick. The tick always takes the pending value held
    // before this cycle, so a press landing in the same cycle waits for the
    // following tick. The tick is honoured on the pause state before any
    // toggle in the same cycle.
    always_comb begin
        dir_d     = dir_q;
        dir_chg_d = 1'b0;
        if (bus.i_Tick && !pause_q) begin
            dir_d     = pending_q;
            dir_chg_d = (pending_q != dir_q);
        end
    end

    // Pause state flips once per accepted pause press.
    always_comb begin
        pause_d = pause_q ^ pause_evt;
    end

    // State registers. Reset overrides everything, including a tick or a
    // press in the same cycle, and never raises o_DirChg.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1_q   <= IDLE_LVL;
            sync2_q   <= IDLE_LVL;
            stable_q  <= IDLE_LVL;
            prev_q    <= IDLE_LVL;
            for (int k = 0; k < NBITS; k++) begin
                cnt_q[k] <= '0;
            end
            pending_q <= DIR_RIGHT;
            dir_q     <= DIR_RIGHT;
            dir_chg_q <= 1'b0;
            pause_q   <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            prev_q    <= prev_d;
            for (int k = 0; k < NBITS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            pending_q <= pending_d;
            dir_q     <= dir_d;
            dir_chg_q <= dir_chg_d;
            pause_q   <= pause_d;
        end
    end

    assign bus.o_Push   = stable_q[3:0];
    assign bus.o_Dir    = dir_q;
    assign bus.o_DirChg = dir_chg_q;
    assign bus.o_Pause  = pause_q;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// ----------------------------------------------------------------------------
// tb_snake_input_ctrl
//
// Directed bench for snake_input_ctrl with DEBOUNCE_CYCLES = 4. Inputs are
// driven and outputs sampled 1 ns after each rising clock edge. Expected
// values are worked out by hand from the block's timing: a raw level change
// shows on o_Push six edges later, the pending heading one edge after that,
// and a tick updates o_Dir / o_DirChg on the edge that samples it.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_snake_input_ctrl;

    localparam int DEB   = 4;
    localparam int CNTW  = 3;

    logic clk;
    logic rst;
    int   compares;
    int   mismatches;

    snake_input_ctrl_if bus_if ();

    snake_input_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CNTW)
    ) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus_if)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compares++;
        if (actual !== expected) begin
            mismatches++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drive all raw inputs at once.
    task automatic applyStimulus(input logic [3:0] push, input logic pause,
                                 input logic tick);
        bus_if.i_Push  = push;
        bus_if.i_Pause = pause;
        bus_if.i_Tick  = tick;
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int n);
        rst = 1'b1;
        waitCycles(n);
        rst = 1'b0;
    endtask

    // Hold a button pattern long enough to be accepted, then release it.
    task automatic pressButton(input logic [3:0] push);
        applyStimulus(push, 1'b0, 1'b0);
        waitCycles(8);
        applyStimulus(4'hF, 1'b0, 1'b0);
        waitCycles(8);
    endtask

    task automatic pulsePause();
        applyStimulus(4'hF, 1'b1, 1'b0);
        waitCycles(8);
        applyStimulus(4'hF, 1'b0, 1'b0);
        waitCycles(8);
    endtask

    // One-cycle tick; on return the commit edge has just happened.
    task automatic pulseTick();
        bus_if.i_Tick = 1'b1;
        waitCycles(1);
        bus_if.i_Tick = 1'b0;
    endtask

    initial begin
        compares   = 0;
        mismatches = 0;
        rst        = 1'b1;
        applyStimulus(4'hF, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Reset and idle.
        doReset(2);
        checkOutput("rst_dir",    32'(bus_if.o_Dir),    32'd3);
        checkOutput("rst_pause",  32'(bus_if.o_Pause),  32'd0);
        checkOutput("rst_push",   32'(bus_if.o_Push),   32'hF);
        checkOutput("rst_dirchg", 32'(bus_if.o_DirChg), 32'd0);
        for (int i = 0; i < 3; i++) begin
            waitCycles(1);
            checkOutput("idle_dirchg", 32'(bus_if.o_DirChg), 32'd0);
        end

        // Up press: o_Push changes exactly six edges after the raw change.
        applyStimulus(4'hE, 1'b0, 1'b0);
        waitCycles(5);
        checkOutput("up_push_early", 32'(bus_if.o_Push), 32'hF);
        waitCycles(1);
        checkOutput("up_push", 32'(bus_if.o_Push), 32'hE);
        waitCycles(2);
        pulseTick();
        checkOutput("up_dir",    32'(bus_if.o_Dir),    32'd0);
        checkOutput("up_dirchg", 32'(bus_if.o_DirChg), 32'd1);
        waitCycles(1);
        checkOutput("up_dirchg_once", 32'(bus_if.o_DirChg), 32'd0);
        applyStimulus(4'hF, 1'b0, 1'b0);
        waitCycles(8);

        // Reversal: left while heading right is refused.
        doReset(1);
        pressButton(4'hB);
        pulseTick();
        checkOutput("rev_dir",    32'(bus_if.o_Dir),    32'd3);
        checkOutput("rev_dirchg", 32'(bus_if.o_DirChg), 32'd0);

        // Up then left between ticks: left is still judged against right.
        doReset(1);
        pressButton(4'hE);
        pressButton(4'hB);
        pulseTick();
        checkOutput("dbl_dir",    32'(bus_if.o_Dir),    32'd0);
        checkOutput("dbl_dirchg", 32'(bus_if.o_DirChg), 32'd1);

        // Three-cycle glitch on down never reaches o_Push.
        doReset(1);
        applyStimulus(4'hD, 1'b0, 1'b0);
        waitCycles(3);
        applyStimulus(4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("glitch_push", 32'(bus_if.o_Push), 32'hF);
            waitCycles(1);
        end
        pulseTick();
        checkOutput("glitch_dir", 32'(bus_if.o_Dir), 32'd3);

        // Up and down together: lowest index (up) wins.
        doReset(1);
        applyStimulus(4'hC, 1'b0, 1'b0);
        waitCycles(8);
        checkOutput("prio_push", 32'(bus_if.o_Push), 32'hC);
        applyStimulus(4'hF, 1'b0, 1'b0);
        waitCycles(8);
        pulseTick();
        checkOutput("prio_dir",    32'(bus_if.o_Dir),    32'd0);
        checkOutput("prio_dirchg", 32'(bus_if.o_DirChg), 32'd1);

        // Press event and tick in the same cycle: tick commits old pending.
        applyStimulus(4'hB, 1'b0, 1'b0);
        waitCycles(6);
        pulseTick();
        checkOutput("same_dir",    32'(bus_if.o_Dir),    32'd0);
        checkOutput("same_dirchg", 32'(bus_if.o_DirChg), 32'd0);
        pulseTick();
        checkOutput("same_dir_next",    32'(bus_if.o_Dir),    32'd2);
        checkOutput("same_dirchg_next", 32'(bus_if.o_DirChg), 32'd1);
        applyStimulus(4'hF, 1'b0, 1'b0);
        waitCycles(8);

        // Pause: pending up is loaded first, then paused ticks must not
        // commit it and paused presses (down) must not replace it.
        pressButton(4'hE);
        applyStimulus(4'hF, 1'b1, 1'b0);
        waitCycles(6);
        checkOutput("pause_early", 32'(bus_if.o_Pause), 32'd0);
        waitCycles(1);
        checkOutput("pause_on", 32'(bus_if.o_Pause), 32'd1);
        applyStimulus(4'hF, 1'b0, 1'b0);
        waitCycles(8);
        checkOutput("pause_hold", 32'(bus_if.o_Pause), 32'd1);
        pulseTick();
        checkOutput("pause_tick_dir",    32'(bus_if.o_Dir),    32'd2);
        checkOutput("pause_tick_dirchg", 32'(bus_if.o_DirChg), 32'd0);
        pressButton(4'hD);
        pulsePause();
        checkOutput("pause_off", 32'(bus_if.o_Pause), 32'd0);
        pulseTick();
        checkOutput("resume_dir",    32'(bus_if.o_Dir),    32'd0);
        checkOutput("resume_dirchg", 32'(bus_if.o_DirChg), 32'd1);

        // Reset while paused clears everything without a change pulse.
        pulsePause();
        checkOutput("repause_on", 32'(bus_if.o_Pause), 32'd1);
        doReset(1);
        checkOutput("rst_pause_clr",  32'(bus_if.o_Pause),  32'd0);
        checkOutput("rst_pause_dir",  32'(bus_if.o_Dir),    32'd3);
        checkOutput("rst_pause_chg",  32'(bus_if.o_DirChg), 32'd0);
        waitCycles(1);
        checkOutput("rst_pause_chg2", 32'(bus_if.o_DirChg), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
